dcache_req_arb: RTL
===================

Name: dcache_req_arb

Overview:
- Round-robin arbiter that shares one dcache controller front end among N_REQ requesters, for example load, store and page-table walker.
- Sits between the requesters and the cache request, ptag and response channels.
- Keeps one transaction in flight at a time: latches the winner's request, issues it to the cache, forwards the winner's late physical tag, and routes the read data back to the winner only.

Parameters:
N_REQ, 3, number of requesters (2..8).
ID_W, 3, width of the internal owner index; must satisfy 2**ID_W >= N_REQ.

Ports:
clock  input  1  single clock.
reset  input  1  synchronous, active-high reset.
req_valid  input  N_REQ  per-requester request valid.
req_opcode  input  2*N_REQ  per-requester opcode, DCACHE_RD or DCACHE_WR from dcache_opcode.vh.
req_wstrb  input  8*N_REQ  per-requester byte strobes.
req_index  input  6*N_REQ  per-requester set index.
req_offset  input  6*N_REQ  per-requester line offset.
req_wdata  input  64*N_REQ  per-requester write data.
req_ready  output  N_REQ  one-hot request accept.
req_ptag_valid  input  N_REQ  per-requester physical tag valid.
req_ptag  input  44*N_REQ  per-requester physical tag.
req_ptag_ready  output  N_REQ  one-hot ptag accept.
resp_valid  output  N_REQ  one-hot read-data valid.
resp_rdata  output  64  read data, shared by all requesters.
resp_ready  input  N_REQ  per-requester response ready.
dc_in_valid  output  1  request valid to cache.
dc_opcode  output  2  latched opcode.
dc_wstrb  output  8  latched strobes.
dc_index  output  6  latched index.
dc_offset  output  6  latched offset.
dc_wdata  output  64  latched write data.
dc_out_ready  input  1  cache accepts request.
dc_ptag_valid  output  1  ptag valid to cache.
dc_ptag  output  44  ptag to cache.
dc_ptag_ready  input  1  cache accepts ptag.
dc_out_valid  input  1  cache read data valid.
dc_rdata  input  64  cache read data.
dc_in_ready  output  1  response ready to cache.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high, takes effect at the clock edge):
  - state goes to IDLE; rr_ptr and owner go to 0; payload registers clear.
  - All valid and ready outputs are 0, except req_ready, which follows the IDLE grant rule.
  - dc_* data outputs are 0; busy is 0.
  - Reset asserted mid-transaction abandons it; no response is delivered afterwards.
- States: IDLE, SEND, PTAG, RESP.
- IDLE:
  - Winner is the first set bit of req_valid, searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - req_ready[winner] = 1 combinationally; all other bits are 0.
  - On the handshake: latch the winner's payload, set owner = winner, set rr_ptr = (winner+1) mod N_REQ, go to SEND.
  - No req_valid bit set: stay in IDLE, rr_ptr unchanged.
- SEND:
  - dc_in_valid = 1; dc_* payload comes from the registers and stays stable.
  - dc_out_ready = 1: go to PTAG. Otherwise hold.
  - Request-to-cache latency: accept in cycle T, dc_in_valid in cycle T+1.
- PTAG:
  - Pass-through: dc_ptag_valid = req_ptag_valid[owner]; dc_ptag = req_ptag[owner]; req_ptag_ready[owner] = dc_ptag_ready. All other ptag_ready bits are 0.
  - Handshake (dc_ptag_valid && dc_ptag_ready): read goes to RESP; write goes to IDLE.
  - Non-owner ptag_valid is ignored.
- RESP:
  - resp_valid[owner] = dc_out_valid; resp_rdata = dc_rdata; dc_in_ready = resp_ready[owner].
  - Handshake (dc_out_valid && resp_ready[owner]): go to IDLE.
  - Non-owner resp_valid bits are always 0.
- Outside IDLE, all req_ready bits are 0. New requests wait; there is no queueing beyond the single latched transaction.
- A requester whose req_valid drops before being granted is simply skipped.
- Opcode values other than DCACHE_RD and DCACHE_WR are treated as write: no RESP phase.
- Simultaneous requests: exactly one is granted per IDLE cycle. Fairness: a continuously requesting agent is granted within N_REQ transactions.
- Wrap: rr_ptr wraps from N_REQ-1 to 0.

Test Plan:
- Single read: requester 1 sends index=0x05, offset=0x08, cache out_ready after 2 cycles, ptag 0x123 one cycle later, dc_rdata=0xDEADBEEF -> req_ready[1] pulses once; dc_in_valid held 2 cycles with index 0x05; dc_ptag=0x123; resp_valid=3'b010 with 0xDEADBEEF; state returns to IDLE.
- Single write: requester 0 sends wstrb=0x0F, wdata=0xA5A5 -> after the ptag handshake the block returns to IDLE with no resp_valid; dc_wstrb=0x0F.
- Round-robin: all three requesters hold req_valid for 6 transactions from reset -> grant order 0,1,2,0,1,2.
- Backpressure: resp_ready[2]=0 for 4 cycles during a read owned by requester 2 -> resp_valid[2] and dc_rdata held, dc_in_ready=0; other req_ready bits stay 0; completes on the cycle resp_ready rises.
- Ptag isolation: requester 0 owns the transaction while requester 1 asserts ptag_valid with 0x777 -> dc_ptag_valid follows requester 0 only; req_ptag_ready[1] never asserts.
- Reset in RESP: assert reset for 1 cycle -> the next cycle is IDLE, all valids 0, rr_ptr 0, busy 0, and the stale dc_out_valid produces no resp_valid.

Source files
------------

// File: rtl/dcache_req_arb.sv
// Round-robin arbiter sharing one dcache controller front end among N_REQ requesters.
// One transaction in flight: latch winner's request, send it, forward its ptag, return read data to it alone.
module dcache_req_arb #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [2*N_REQ-1:0]    req_opcode,
    input  logic [8*N_REQ-1:0]    req_wstrb,
    input  logic [6*N_REQ-1:0]    req_index,
    input  logic [6*N_REQ-1:0]    req_offset,
    input  logic [64*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_ptag_valid,
    input  logic [44*N_REQ-1:0]   req_ptag,
    output logic [N_REQ-1:0]      req_ptag_ready,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [63:0]           resp_rdata,
    input  logic [N_REQ-1:0]      resp_ready,
    output logic                  dc_in_valid,
    output logic [1:0]            dc_opcode,
    output logic [7:0]            dc_wstrb,
    output logic [5:0]            dc_index,
    output logic [5:0]            dc_offset,
    output logic [63:0]           dc_wdata,
    input  logic                  dc_out_ready,
    output logic                  dc_ptag_valid,
    output logic [43:0]           dc_ptag,
    input  logic                  dc_ptag_ready,
    input  logic                  dc_out_valid,
    input  logic [63:0]           dc_rdata,
    output logic                  dc_in_ready,
    output logic                  busy
);

    localparam logic [1:0] DCACHE_RD = 2'b00;
    localparam int         N_SLOT    = 2 ** ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        PTAG = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t              state_r;
    state_t              state_n_s;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     owner_r;
    logic [1:0]          op_r;
    logic [7:0]          wstrb_r;
    logic [5:0]          index_r;
    logic [5:0]          offset_r;
    logic [63:0]         wdata_r;

    logic                win_found_s;
    logic [ID_W-1:0]     win_id_s;
    logic [ID_W-1:0]     scan_id_s;
    logic                grant_fire_s;
    logic                ptag_valid_sel_s;
    logic                resp_ready_sel_s;

    // Per-slot views padded to 2**ID_W entries so owner/winner indexing is always in range.
    logic                valid_pad_s      [N_SLOT];
    logic                ptag_valid_pad_s [N_SLOT];
    logic                resp_ready_pad_s [N_SLOT];
    logic [1:0]          op_arr_s         [N_SLOT];
    logic [7:0]          wstrb_arr_s      [N_SLOT];
    logic [5:0]          index_arr_s      [N_SLOT];
    logic [5:0]          offset_arr_s     [N_SLOT];
    logic [63:0]         wdata_arr_s      [N_SLOT];
    logic [43:0]         ptag_arr_s       [N_SLOT];

    for (genvar g = 0; g < N_SLOT; g++) begin : g_slot
        if (g < N_REQ) begin : g_live
            assign valid_pad_s[g]      = req_valid[g];
            assign ptag_valid_pad_s[g] = req_ptag_valid[g];
            assign resp_ready_pad_s[g] = resp_ready[g];
            assign op_arr_s[g]         = req_opcode[2*g +: 2];
            assign wstrb_arr_s[g]      = req_wstrb[8*g +: 8];
            assign index_arr_s[g]      = req_index[6*g +: 6];
            assign offset_arr_s[g]     = req_offset[6*g +: 6];
            assign wdata_arr_s[g]      = req_wdata[64*g +: 64];
            assign ptag_arr_s[g]       = req_ptag[44*g +: 44];
        end else begin : g_pad
            assign valid_pad_s[g]      = 1'b0;
            assign ptag_valid_pad_s[g] = 1'b0;
            assign resp_ready_pad_s[g] = 1'b0;
            assign op_arr_s[g]         = 2'b00;
            assign wstrb_arr_s[g]      = 8'h00;
            assign index_arr_s[g]      = 6'h00;
            assign offset_arr_s[g]     = 6'h00;
            assign wdata_arr_s[g]      = 64'h0;
            assign ptag_arr_s[g]       = 44'h0;
        end
    end

    // Round-robin winner search; scanning downward lets the slot closest to rr_ptr win last.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        scan_id_s   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_id_s = ID_W'((int'(rr_ptr_r) + i) % N_REQ);
            if (valid_pad_s[scan_id_s]) begin
                win_found_s = 1'b1;
                win_id_s    = scan_id_s;
            end else begin
                win_id_s    = win_id_s;
            end
        end
    end

    assign ptag_valid_sel_s = ptag_valid_pad_s[owner_r];
    assign resp_ready_sel_s = resp_ready_pad_s[owner_r];

    // Next-state and handshake outputs for the single in-flight transaction.
    always_comb begin
        state_n_s      = state_r;
        grant_fire_s   = 1'b0;
        req_ready      = '0;
        req_ptag_ready = '0;
        resp_valid     = '0;
        resp_rdata     = 64'h0;
        dc_in_valid    = 1'b0;
        dc_ptag_valid  = 1'b0;
        dc_ptag        = 44'h0;
        dc_in_ready    = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    for (int j = 0; j < N_REQ; j++) begin
                        req_ready[j] = (win_id_s == ID_W'(j));
                    end
                    grant_fire_s = 1'b1;
                    state_n_s    = SEND;
                end else begin
                    state_n_s    = IDLE;
                end
            end
            SEND: begin
                dc_in_valid = 1'b1;
                if (dc_out_ready) begin
                    state_n_s = PTAG;
                end else begin
                    state_n_s = SEND;
                end
            end
            PTAG: begin
                dc_ptag_valid = ptag_valid_sel_s;
                dc_ptag       = ptag_arr_s[owner_r];
                for (int j = 0; j < N_REQ; j++) begin
                    req_ptag_ready[j] = (owner_r == ID_W'(j)) && dc_ptag_ready;
                end
                // Any opcode other than a read completes without a response phase.
                if (ptag_valid_sel_s && dc_ptag_ready) begin
                    state_n_s = (op_r == DCACHE_RD) ? RESP : IDLE;
                end else begin
                    state_n_s = PTAG;
                end
            end
            RESP: begin
                for (int j = 0; j < N_REQ; j++) begin
                    resp_valid[j] = (owner_r == ID_W'(j)) && dc_out_valid;
                end
                resp_rdata  = dc_rdata;
                dc_in_ready = resp_ready_sel_s;
                if (dc_out_valid && resp_ready_sel_s) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = RESP;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State, round-robin pointer, owner and latched payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            op_r     <= 2'b00;
            wstrb_r  <= 8'h00;
            index_r  <= 6'h00;
            offset_r <= 6'h00;
            wdata_r  <= 64'h0;
        end else begin
            state_r <= state_n_s;
            if (grant_fire_s) begin
                owner_r  <= win_id_s;
                rr_ptr_r <= (win_id_s == ID_W'(N_REQ - 1)) ? '0 : win_id_s + ID_W'(1);
                op_r     <= op_arr_s[win_id_s];
                wstrb_r  <= wstrb_arr_s[win_id_s];
                index_r  <= index_arr_s[win_id_s];
                offset_r <= offset_arr_s[win_id_s];
                wdata_r  <= wdata_arr_s[win_id_s];
            end
        end
    end

    assign dc_opcode = op_r;
    assign dc_wstrb  = wstrb_r;
    assign dc_index  = index_r;
    assign dc_offset = offset_r;
    assign dc_wdata  = wdata_r;
    assign busy      = (state_r != IDLE);

endmodule
